bus_bridge_uart_frame_master: RTL
=================================

// Module: bus_bridge_uart_frame_master
// PURPOSE
//  Generalised UART-framed bus master front end. Decodes sync-delimited request frames from
//  a UART byte stream into bridge requests, buffered in a request FIFO. Encodes bridge
//  responses back into framed UART bytes. Sits between the uart core and bus_bridge_master_if.
// PARAMETERS
//  ADDR_W         16     request address width; multiple of 8, ABYTES = ADDR_W/8
//  DATA_W         8      read/write data width; multiple of 8, DBYTES = DATA_W/8
//  FIFO_DEPTH     4      request FIFO entries; power of 2, >= 2
//  SYNC_BYTE      8'hA5  frame start marker (both directions)
//  TIMEOUT_CYC    50000  max clk cycles between bytes inside a frame; must be > 0
// PORTS
//  clk            in   1       clock
//  rst_n          in   1       reset, asynchronous, active-low
//  rx_data        in   8       received byte from uart
//  rx_valid       in   1       one-cycle strobe: rx_data valid
//  tx_data        out  8       byte to uart
//  tx_wr_en       out  1       one-cycle write strobe to uart
//  tx_busy        in   1       uart transmitter busy
//  req_valid      out  1       FIFO head valid
//  req_ready      in   1       bridge accepts head
//  req_addr       out  ADDR_W  head address
//  req_wdata      out  DATA_W  head write data
//  req_is_write   out  1       head direction
//  resp_valid     in   1       bridge response valid
//  resp_ready     out  1       high only in TX_IDLE
//  resp_rdata     in   DATA_W  read data
//  resp_is_write  in   1       echoed direction
//  frame_err_cnt  out  8       saturating count: timeouts, bad checksums
//  drop_cnt       out  8       saturating count: frames lost to full FIFO
// BEHAVIOUR
//  Reset: all outputs 0; rx FSM in HUNT; tx FSM in TX_IDLE; FIFO empty; counters 0.
//  Request frame: SYNC, ABYTES addr (LSB first), DBYTES data (LSB first), FLAGS (bit0=is_write;
//  bits7:1 ignored) [, CSUM]. Reads still carry data bytes; they are ignored.
//  RX FSM: HUNT -> ADDR -> DATA -> FLAGS [-> CSUM] -> HUNT. A byte counter indexes the byte
//  lanes. In HUNT, non-SYNC bytes are discarded.
//  - Push on final byte: 1 cycle after its rx_valid, the frame is pushed if the FIFO is not full.
//    If the FIFO is full, the frame is dropped and drop_cnt increments.
//  - Pop when req_valid && req_ready; push and pop in the same cycle on a full FIFO is legal.
//  - Gap timer: cleared on every rx_valid; runs outside HUNT. On reaching TIMEOUT_CYC: go to
//    HUNT, discard the partial frame, increment frame_err_cnt.
//  - A SYNC byte mid-frame is treated as data (no resync).
//  - Latency: req_valid rises 2 cycles after the last frame byte's rx_valid when the FIFO was
//    empty.
//  TX FSM: TX_IDLE -> SEND -> WAIT -> SEND ... -> TX_IDLE.
//  - Response is captured on resp_valid && resp_ready.
//  - Byte sequence: SYNC, DBYTES rdata (LSB first), STATUS={7'b0,is_write} [, CSUM].
//  - SEND: when !tx_busy, drive tx_data and pulse tx_wr_en for 1 cycle.
//  - WAIT: wait for a tx_busy falling edge (registered busy_d && !tx_busy), then SEND the next
//    byte or return to TX_IDLE.
//  RX and TX are independent; responses may overlap incoming frames.
//  Counters saturate at 8'hFF. A reset mid-frame or mid-transmission abandons all state.
// CONFIGURATION
//  BUS_BRIDGE_UART_CSUM_EN defined:
//  - Request frames carry a trailing CSUM = XOR of all bytes after SYNC.
//  - Mismatch: frame discarded, frame_err_cnt increments, no push.
//  - Responses append CSUM = XOR of rdata bytes and STATUS.
//  Undefined: no CSUM byte in either direction; FLAGS is the final request byte.
// STRUCTURE
//  bus_bridge_pkg: SYNC default, FLAG_WRITE_BIT, rx_state_t, tx_state_t, parametrised frame
//  length helper functions.
//  Sub-module bus_bridge_req_fifo: synchronous FIFO of {addr,wdata,is_write} with full/empty
//  flags, count, and registered head outputs.
// TESTING
//  - Write frame A5 34 12 5A 01 (CSUM off, defaults) -> req_addr=16'h1234, req_wdata=8'h5A,
//    req_is_write=1; 1 push.
//  - resp_rdata=8'hC3, resp_is_write=0 -> tx bytes A5 C3 00, each written only after the prior
//    busy falls.
//  - 5 frames with req_ready=0, FIFO_DEPTH=4 -> 4 queued, drop_cnt=1; release -> FIFO order
//    preserved.
//  - A5 34 then idle TIMEOUT_CYC cycles -> frame_err_cnt=1, no push; next full frame accepted.
//  - CSUM_EN: A5 34 12 5A 01 7D accepted; same frame with CSUM 00 -> rejected,
//    frame_err_cnt=1.
//  - Junk bytes 00 FF before SYNC ignored; rst_n low mid-frame -> all outputs 0, next frame
//    decodes cleanly.

Source files
------------

// File: rtl/bus_bridge_pkg.sv
// bus_bridge_pkg: shared constants, FSM state types and frame-length helpers for the UART bus bridge.
// Frame lengths grow by one checksum byte when BUS_BRIDGE_UART_CSUM_EN is defined.
package bus_bridge_pkg;
   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
   localparam int FLAG_WRITE_BIT = 0;
   typedef enum logic [2:0] {HUNT, ADDR, DATA, FLAGS, CSUM} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, SEND, WAIT} tx_state_t;
   function automatic int req_frame_len(input int abytes, input int dbytes);
`ifdef BUS_BRIDGE_UART_CSUM_EN
      return abytes + dbytes + 3;
`else
      return abytes + dbytes + 2;
`endif
   endfunction
   function automatic int resp_frame_len(input int dbytes);
`ifdef BUS_BRIDGE_UART_CSUM_EN
      return dbytes + 3;
`else
      return dbytes + 2;
`endif
   endfunction
endpackage

// File: rtl/bus_bridge_req_fifo.sv
// bus_bridge_req_fifo: synchronous request FIFO with full/empty flags, occupancy count and register-fed head.
module bus_bridge_req_fifo #(
   parameter int W = 25,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
   logic [W-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0] count_q, count_d;
   logic do_push, do_pop;
   always_comb begin
      do_pop = pop && count_q != '0;
      // a full FIFO still accepts a push when the head leaves in the same cycle
      do_push = push && (count_q != FULL_CNT || do_pop);
      wr_ptr_d = wr_ptr_q + PW'(do_push);
      rd_ptr_d = rd_ptr_q + PW'(do_pop);
      count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q <= count_d;
         if (do_push) mem_q[wr_ptr_q] <= din;
      end
   end
   assign head = mem_q[rd_ptr_q];
   assign full = count_q == FULL_CNT;
   assign empty = count_q == '0;
   assign count = count_q;
endmodule

// File: rtl/bus_bridge_uart_frame_master.sv
// bus_bridge_uart_frame_master: decodes SYNC-framed UART requests into a request FIFO and frames responses back.
// Define BUS_BRIDGE_UART_CSUM_EN to append and check an XOR checksum byte in both directions.
module bus_bridge_uart_frame_master
   import bus_bridge_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int FIFO_DEPTH = 4,
   parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [7:0]        tx_data,
   output logic              tx_wr_en,
   input  logic              tx_busy,
   output logic              req_valid,
   input  logic              req_ready,
   output logic [ADDR_W-1:0] req_addr,
   output logic [DATA_W-1:0] req_wdata,
   output logic              req_is_write,
   input  logic              resp_valid,
   output logic              resp_ready,
   input  logic [DATA_W-1:0] resp_rdata,
   input  logic              resp_is_write,
   output logic [7:0]        frame_err_cnt,
   output logic [7:0]        drop_cnt
);
   localparam int AB = ADDR_W / 8;
   localparam int DB = DATA_W / 8;
   localparam int FW = ADDR_W + DATA_W + 1;
   localparam int GW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [7:0] TX_LAST = 8'(resp_frame_len(DB) - 1);
   rx_state_t rx_state_q, rx_state_d;
   tx_state_t tx_state_q, tx_state_d;
   logic [7:0] rx_cnt_q, rx_cnt_d, csum_q, csum_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic wr_q, wr_d, fire_q, fire_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [7:0] frame_err_cnt_q, frame_err_cnt_d, drop_cnt_q, drop_cnt_d;
   logic timeout, bad, push, pop, full, empty;
   logic [FW-1:0] head;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic [7:0] tx_cnt_q, tx_cnt_d, status_q, status_d, tx_data_q, tx_data_d, tx_byte, tx_csum;
   logic tx_wr_en_q, tx_wr_en_d, busy_q, resp_ready_q, resp_ready_d;
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d = rx_cnt_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      wr_d = wr_q;
      csum_d = csum_q;
      fire_d = 1'b0;
      bad = 1'b0;
      gap_d = (rx_valid || rx_state_q == HUNT) ? '0 : gap_q + 1'b1;
      timeout = rx_state_q != HUNT && !rx_valid && gap_q == GW'(TIMEOUT_CYC - 1);
      if (timeout) rx_state_d = HUNT;
      else if (rx_valid) begin
         csum_d = csum_q ^ rx_data;
         rx_cnt_d = rx_cnt_q + 1'b1;
         case (rx_state_q)
            HUNT: begin
               csum_d = '0;
               rx_cnt_d = '0;
               rx_state_d = rx_data == SYNC_BYTE ? ADDR : HUNT;
            end
            ADDR: begin
               for (int i = 0; i < AB; i++) if (rx_cnt_q == 8'(i)) addr_d[8*i +: 8] = rx_data;
               if (rx_cnt_q == 8'(AB - 1)) begin
                  rx_state_d = DATA;
                  rx_cnt_d = '0;
               end
            end
            DATA: begin
               for (int i = 0; i < DB; i++) if (rx_cnt_q == 8'(i)) wdata_d[8*i +: 8] = rx_data;
               if (rx_cnt_q == 8'(DB - 1)) begin
                  rx_state_d = FLAGS;
                  rx_cnt_d = '0;
               end
            end
            FLAGS: begin
               wr_d = rx_data[FLAG_WRITE_BIT];
`ifdef BUS_BRIDGE_UART_CSUM_EN
               rx_state_d = CSUM;
`else
               rx_state_d = HUNT;
               fire_d = 1'b1;
`endif
            end
            default: begin
               rx_state_d = HUNT;
               fire_d = csum_q == rx_data;
               bad = csum_q != rx_data;
            end
         endcase
      end
      // the assembled frame registers stay stable during the cycle after the final byte
      pop = req_ready && fifo_count != '0;
      push = fire_q && (!full || pop);
      frame_err_cnt_d = ((timeout || bad) && frame_err_cnt_q != 8'hFF) ? frame_err_cnt_q + 1'b1 : frame_err_cnt_q;
      drop_cnt_d = (fire_q && !push && drop_cnt_q != 8'hFF) ? drop_cnt_q + 1'b1 : drop_cnt_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_q <= HUNT;
         rx_cnt_q <= '0;
         addr_q <= '0;
         wdata_q <= '0;
         wr_q <= 1'b0;
         csum_q <= '0;
         fire_q <= 1'b0;
         gap_q <= '0;
         frame_err_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q <= rx_cnt_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         wr_q <= wr_d;
         csum_q <= csum_d;
         fire_q <= fire_d;
         gap_q <= gap_d;
         frame_err_cnt_q <= frame_err_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end
   bus_bridge_req_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rst_n(rst_n),
      .push(push),
      .pop(pop),
      .din({wr_q, wdata_q, addr_q}),
      .head(head),
      .full(full),
      .empty(empty),
      .count(fifo_count)
   );
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d = tx_cnt_q;
      rdata_d = rdata_q;
      status_d = status_q;
      tx_data_d = tx_data_q;
      tx_wr_en_d = 1'b0;
      tx_csum = status_q;
      for (int i = 0; i < DB; i++) tx_csum = tx_csum ^ rdata_q[8*i +: 8];
      tx_byte = SYNC_BYTE;
      for (int i = 0; i < DB; i++) if (tx_cnt_q == 8'(i + 1)) tx_byte = rdata_q[8*i +: 8];
      if (tx_cnt_q == 8'(DB + 1)) tx_byte = status_q;
      if (tx_cnt_q == 8'(DB + 2)) tx_byte = tx_csum;
      case (tx_state_q)
         TX_IDLE: if (resp_valid && resp_ready_q) begin
            rdata_d = resp_rdata;
            status_d = {7'b0, resp_is_write};
            tx_cnt_d = '0;
            tx_state_d = SEND;
         end
         SEND: if (!tx_busy) begin
            tx_data_d = tx_byte;
            tx_wr_en_d = 1'b1;
            tx_state_d = WAIT;
         end
         default: if (busy_q && !tx_busy) begin
            tx_state_d = tx_cnt_q == TX_LAST ? TX_IDLE : SEND;
            tx_cnt_d = tx_cnt_q + 1'b1;
         end
      endcase
      resp_ready_d = tx_state_d == TX_IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q <= '0;
         rdata_q <= '0;
         status_q <= '0;
         tx_data_q <= '0;
         tx_wr_en_q <= 1'b0;
         busy_q <= 1'b0;
         resp_ready_q <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q <= tx_cnt_d;
         rdata_q <= rdata_d;
         status_q <= status_d;
         tx_data_q <= tx_data_d;
         tx_wr_en_q <= tx_wr_en_d;
         busy_q <= tx_busy;
         resp_ready_q <= resp_ready_d;
      end
   end
   assign tx_data = tx_data_q;
   assign tx_wr_en = tx_wr_en_q;
   assign resp_ready = resp_ready_q;
   assign req_valid = !empty;
   assign {req_is_write, req_wdata, req_addr} = head;
   assign frame_err_cnt = frame_err_cnt_q;
   assign drop_cnt = drop_cnt_q;
endmodule
